// File: rtl/bcd_chain_counter.sv
// Synchronous multi-digit BCD counter with preset load, wrap pulse and 7-segment decode.
// Optional down-counting is compiled in with `define BCD_CHAIN_DOWN_EN.
module bcd_chain_counter #(
  parameter int DIGITS    = 2,
  parameter int MAX_COUNT = 59,
  parameter int CLK_HZ    = 1000000,
  parameter int TICK_HZ   = 1
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  pause,
  input  logic                  timer,
  input  logic                  down,
  input  logic                  load,
  input  logic [4*DIGITS-1:0]   load_value,
  output logic [4*DIGITS-1:0]   count_bcd,
  output logic [7*DIGITS-1:0]   segments,
  output logic                  wrap,
  output logic                  load_err
);

  localparam int DIV = CLK_HZ / TICK_HZ;
  localparam int DW  = (DIV > 1) ? $clog2(DIV) : 1;

  function automatic longint pow10(input int n);
    longint r;
    r = 1;
    for (int i = 0; i < n; i++) r = r * 10;
    return r;
  endfunction

  function automatic logic [4*DIGITS-1:0] to_bcd(input longint v);
    logic [4*DIGITS-1:0] r;
    longint t;
    r = '0;
    t = v;
    for (int k = 0; k < DIGITS; k++) begin
      r[4*k +: 4] = 4'(t % 10);
      t = t / 10;
    end
    return r;
  endfunction

  function automatic logic [6:0] seg7(input logic [3:0] d);
    case (d)
      4'd0:    seg7 = 7'h3F;
      4'd1:    seg7 = 7'h06;
      4'd2:    seg7 = 7'h5B;
      4'd3:    seg7 = 7'h4F;
      4'd4:    seg7 = 7'h66;
      4'd5:    seg7 = 7'h6D;
      4'd6:    seg7 = 7'h7D;
      4'd7:    seg7 = 7'h07;
      4'd8:    seg7 = 7'h7F;
      4'd9:    seg7 = 7'h6F;
      default: seg7 = 7'h00;
    endcase
  endfunction

  if (DIGITS < 1 || DIGITS > 8) begin : g_bad_digits
    $error("bcd_chain_counter: DIGITS must be in 1..8");
  end
  if (MAX_COUNT < 0 || longint'(MAX_COUNT) > pow10(DIGITS) - 1) begin : g_bad_max
    $error("bcd_chain_counter: MAX_COUNT does not fit in DIGITS decimal digits");
  end
  if (DIV < 2 || (CLK_HZ % TICK_HZ) != 0) begin : g_bad_div
    $error("bcd_chain_counter: CLK_HZ/TICK_HZ must be an integer of at least 2");
  end

  localparam logic [4*DIGITS-1:0] MAX_BCD  = to_bcd(longint'(MAX_COUNT));
  localparam logic [DW-1:0]       DIV_LAST = DW'(DIV - 1);

  logic [DW-1:0]       div_q, div_d;
  logic [4*DIGITS-1:0] count_q, count_d;
  logic                wrap_q, wrap_d;
  logic                err_q, err_d;
  logic                tick, step;
  logic                digits_ok, load_ok;
  logic [4*DIGITS-1:0] inc_val;
  logic                inc_carry;

  assign tick   = (div_q == DIV_LAST);
  assign div_d  = tick ? '0 : div_q + DW'(1);
  assign step   = !pause && (timer ? tick : 1'b1);

  // With every nibble in 0..9, a plain unsigned compare of packed BCD orders like the decimal value.
  always_comb begin
    digits_ok = 1'b1;
    for (int k = 0; k < DIGITS; k++) begin
      if (load_value[4*k +: 4] > 4'd9) digits_ok = 1'b0;
    end
  end
  assign load_ok = digits_ok && (load_value <= MAX_BCD);

  always_comb begin
    inc_val   = count_q;
    inc_carry = 1'b1;
    for (int k = 0; k < DIGITS; k++) begin
      if (inc_carry) begin
        if (count_q[4*k +: 4] == 4'd9) begin
          inc_val[4*k +: 4] = 4'd0;
        end else begin
          inc_val[4*k +: 4] = count_q[4*k +: 4] + 4'd1;
          inc_carry         = 1'b0;
        end
      end
    end
  end

`ifdef BCD_CHAIN_DOWN_EN
  logic [4*DIGITS-1:0] dec_val;
  logic                dec_borrow;

  always_comb begin
    dec_val    = count_q;
    dec_borrow = 1'b1;
    for (int k = 0; k < DIGITS; k++) begin
      if (dec_borrow) begin
        if (count_q[4*k +: 4] == 4'd0) begin
          dec_val[4*k +: 4] = 4'd9;
        end else begin
          dec_val[4*k +: 4] = count_q[4*k +: 4] - 4'd1;
          dec_borrow        = 1'b0;
        end
      end
    end
  end
`else
  logic unused_down;
  assign unused_down = down;
`endif

  // A load, accepted or not, always takes the cycle away from stepping.
  always_comb begin
    count_d = count_q;
    wrap_d  = 1'b0;
    err_d   = 1'b0;
    if (load) begin
      if (load_ok) count_d = load_value;
      else         err_d   = 1'b1;
    end else if (step) begin
`ifdef BCD_CHAIN_DOWN_EN
      if (down) begin
        if (count_q == '0) begin
          count_d = MAX_BCD;
          wrap_d  = 1'b1;
        end else begin
          count_d = dec_val;
        end
      end else
`endif
      begin
        if (count_q == MAX_BCD) begin
          count_d = '0;
          wrap_d  = 1'b1;
        end else begin
          count_d = inc_val;
        end
      end
    end
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      div_q   <= '0;
      count_q <= '0;
      wrap_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      div_q   <= div_d;
      count_q <= count_d;
      wrap_q  <= wrap_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    segments = '0;
    for (int k = 0; k < DIGITS; k++) begin
      segments[7*k +: 7] = seg7(count_q[4*k +: 4]);
    end
  end

  assign count_bcd = count_q;
  assign wrap      = wrap_q;
  assign load_err  = err_q;

endmodule

// File: tb/tb_bcd_chain_counter.sv
// Bench for bcd_chain_counter: a 2-digit (0..59, tick every 10 clocks) and a 4-digit (0..9999) instance
// checked every cycle against an integer reference model under directed and random stimulus.
module tb_bcd_chain_counter;

  logic        CLK = 1'b0;
  logic        RST;
  logic        pause, timer, down, load;
  logic [7:0]  load_value;
  logic [7:0]  a_count;
  logic [13:0] a_seg;
  logic        a_wrap, a_err;

  logic        b_pause, b_load;
  logic [15:0] b_lv;
  logic [15:0] b_count;
  logic [27:0] b_seg;
  logic        b_wrap, b_err;

  int n_checks = 0;
  int n_errors = 0;

  int ma_cnt, mb_cnt, m_div;
  bit ma_wrap, ma_err, mb_wrap, mb_err;

  logic [6:0] seg_tab [0:9] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};

  always #5 CLK = ~CLK;

  bcd_chain_counter #(.DIGITS(2), .MAX_COUNT(59), .CLK_HZ(10), .TICK_HZ(1)) u_a (
    .CLK(CLK), .RST(RST), .pause(pause), .timer(timer), .down(down), .load(load),
    .load_value(load_value), .count_bcd(a_count), .segments(a_seg), .wrap(a_wrap), .load_err(a_err)
  );

  bcd_chain_counter #(.DIGITS(4), .MAX_COUNT(9999), .CLK_HZ(10), .TICK_HZ(1)) u_b (
    .CLK(CLK), .RST(RST), .pause(b_pause), .timer(1'b0), .down(1'b0), .load(b_load),
    .load_value(b_lv), .count_bcd(b_count), .segments(b_seg), .wrap(b_wrap), .load_err(b_err)
  );

  function automatic logic [31:0] int2bcd(input int v);
    logic [31:0] r;
    int t;
    r = '0;
    t = v;
    for (int k = 0; k < 8; k++) begin
      r[4*k +: 4] = 4'(t % 10);
      t = t / 10;
    end
    return r;
  endfunction

  function automatic logic [31:0] seg_exp(input int v, input int digits);
    logic [31:0] r;
    int t;
    r = '0;
    t = v;
    for (int k = 0; k < digits; k++) begin
      r[7*k +: 7] = seg_tab[t % 10];
      t = t / 10;
    end
    return r;
  endfunction

  // Returns -1 when any nibble is not a decimal digit.
  function automatic int bcd_val(input logic [31:0] lv, input int digits);
    int v, w;
    logic [3:0] nib;
    v = 0;
    w = 1;
    for (int k = 0; k < digits; k++) begin
      nib = lv[4*k +: 4];
      if (nib > 4'd9) return -1;
      v = v + int'(nib) * w;
      w = w * 10;
    end
    return v;
  endfunction

  task automatic model_next(input int cnt, input int max, input int digits, input bit stp, input bit dn,
                            input bit ld, input logic [31:0] lv, output int ncnt, output bit nwrap,
                            output bit nerr);
    int v;
    ncnt  = cnt;
    nwrap = 1'b0;
    nerr  = 1'b0;
    if (ld) begin
      v = bcd_val(lv, digits);
      if (v >= 0 && v <= max) ncnt = v;
      else nerr = 1'b1;
    end else if (stp) begin
      if (dn) begin
        if (cnt == 0) begin ncnt = max; nwrap = 1'b1; end
        else ncnt = cnt - 1;
      end else begin
        if (cnt == max) begin ncnt = 0; nwrap = 1'b1; end
        else ncnt = cnt + 1;
      end
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %h expected %h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic check_all();
    chk("a_count", {24'h0, a_count}, int2bcd(ma_cnt));
    chk("a_segments", {18'h0, a_seg}, seg_exp(ma_cnt, 2));
    chk("a_wrap", {31'h0, a_wrap}, {31'h0, ma_wrap});
    chk("a_load_err", {31'h0, a_err}, {31'h0, ma_err});
    chk("b_count", {16'h0, b_count}, int2bcd(mb_cnt));
    chk("b_segments", {4'h0, b_seg}, seg_exp(mb_cnt, 4));
    chk("b_wrap", {31'h0, b_wrap}, {31'h0, mb_wrap});
    chk("b_load_err", {31'h0, b_err}, {31'h0, mb_err});
  endtask

  task automatic model_reset();
    ma_cnt = 0; mb_cnt = 0; m_div = 0;
    ma_wrap = 0; ma_err = 0; mb_wrap = 0; mb_err = 0;
  endtask

  // One clock: predict from the inputs currently applied, take the edge, then compare.
  task automatic step_clk();
    bit tick, a_step, b_step, dn;
    int na, nb;
    bit wa, ea, wb, eb;
    tick   = (m_div == 9);
    a_step = !pause && (timer ? tick : 1'b1);
    b_step = !b_pause;
`ifdef BCD_CHAIN_DOWN_EN
    dn = down;
`else
    dn = 1'b0;
`endif
    model_next(ma_cnt, 59, 2, a_step, dn, load, {24'h0, load_value}, na, wa, ea);
    model_next(mb_cnt, 9999, 4, b_step, 1'b0, b_load, {16'h0, b_lv}, nb, wb, eb);
    @(posedge CLK);
    #1;
    ma_cnt = na; ma_wrap = wa; ma_err = ea;
    mb_cnt = nb; mb_wrap = wb; mb_err = eb;
    m_div  = (m_div + 1) % 10;
    check_all();
  endtask

  initial begin
    RST = 1'b0;
    pause = 1'b0; timer = 1'b0; down = 1'b0; load = 1'b0; load_value = 8'h00;
    b_pause = 1'b1; b_load = 1'b0; b_lv = 16'h0000;
    model_reset();

    // Reset state
    #1;
    check_all();
    repeat (3) @(posedge CLK);
    #1;
    check_all();
    RST = 1'b1;

    // Free-run through a full wrap
    repeat (65) step_clk();

    // Timer mode, pause, release
    timer = 1'b1;
    repeat (35) step_clk();
    pause = 1'b1;
    repeat (25) step_clk();
    pause = 1'b0;
    repeat (30) step_clk();

    // Loads: accepted while paused, rejected digit, rejected range, load beats step
    pause = 1'b1; timer = 1'b0;
    load = 1'b1; load_value = 8'h42; step_clk();
    load_value = 8'h7A; step_clk();
    load_value = 8'h60; step_clk();
    pause = 1'b0;
    load_value = 8'h15; step_clk();
    load = 1'b0; repeat (3) step_clk();
    load = 1'b1; load_value = 8'h59; step_clk();
    load = 1'b0; repeat (2) step_clk();

    // Four-digit chain: full carry, top wrap, invalid nibble
    b_load = 1'b1; b_lv = 16'h0999; step_clk();
    b_load = 1'b0; b_pause = 1'b0; step_clk();
    b_pause = 1'b1;
    b_load = 1'b1; b_lv = 16'h9999; step_clk();
    b_load = 1'b0; b_pause = 1'b0; repeat (2) step_clk();
    b_pause = 1'b1;
    b_load = 1'b1; b_lv = 16'h9A99; step_clk();
    b_load = 1'b0; step_clk();

`ifdef BCD_CHAIN_DOWN_EN
    pause = 1'b0; timer = 1'b0;
    load = 1'b1; load_value = 8'h01; step_clk();
    load = 1'b0; down = 1'b1; repeat (3) step_clk();
    load = 1'b1; load_value = 8'h10; step_clk();
    load = 1'b0; step_clk();
    down = 1'b0; repeat (2) step_clk();
`endif

    // Random mix of every control
    for (int i = 0; i < 400; i++) begin
      pause   = ($urandom_range(0, 3) == 0);
      timer   = ($urandom_range(0, 2) == 0);
      down    = $urandom_range(0, 1) == 1;
      load    = ($urandom_range(0, 9) == 0);
      load_value = ($urandom_range(0, 1) == 1) ? 8'(int2bcd($urandom_range(0, 59))) : 8'($urandom);
      b_pause = ($urandom_range(0, 3) == 0);
      b_load  = ($urandom_range(0, 9) == 0);
      b_lv    = ($urandom_range(0, 1) == 1) ? 16'(int2bcd($urandom_range(9990, 9999))) : 16'($urandom);
      step_clk();
    end

    // Asynchronous reset in the middle of a cycle
    pause = 1'b0; timer = 1'b0; load = 1'b0; down = 1'b0; b_pause = 1'b0; b_load = 1'b0;
    repeat (7) step_clk();
    #3;
    RST = 1'b0;
    #1;
    model_reset();
    check_all();
    @(posedge CLK);
    #1;
    check_all();
    RST = 1'b1;
    repeat (15) step_clk();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/bcd_chain_counter.md
Name: bcd_chain_counter

Overview:
Parametrised, fully synchronous multi-digit BCD counter with per-digit 7-segment outputs. It is the successor to the two-digit ripple counter: digit count, wrap limit and tick rate are configurable, and it adds preset load, a wrap pulse and optional down-counting. All digits run on one clock with clock-enable stepping, not ripple clocking. It sits between the board clock/switches and the seven-segment displays.

Parameters:
DIGITS, 2, number of BCD digits; legal range 1..8.
MAX_COUNT, 59, terminal decimal value before wrap; must be at most 10^DIGITS-1, otherwise elaboration fails.
CLK_HZ, 1000000, input clock frequency in Hz.
TICK_HZ, 1, step rate in timer mode; CLK_HZ/TICK_HZ must be an integer of at least 2.

Ports:
CLK  in  1  system clock; all state updates on the rising edge.
RST  in  1  asynchronous, active-low reset.
pause  in  1  1 = hold the count; 0 = run.
timer  in  1  1 = step once per divided tick; 0 = step every CLK cycle.
down  in  1  count direction, 1 = down; used only with BCD_CHAIN_DOWN_EN.
load  in  1  1-cycle preset strobe.
load_value  in  4*DIGITS  BCD preset value; digit 0 is in bits [3:0].
count_bcd  out  4*DIGITS  current count in BCD; digit 0 is in bits [3:0].
segments  out  7*DIGITS  active-high segments per digit; bit 0 = a ... bit 6 = g; digit k occupies bits [7k+6:7k].
wrap  out  1  1-cycle pulse on wrap-around.
load_err  out  1  1-cycle pulse when a load is rejected.

Behaviour:
- Reset (RST=0, asynchronous):
  - count_bcd=0, divider=0.
  - wrap=0, load_err=0.
  - segments = 7'h3F on every digit.
- Divider:
  - Counts 0..CLK_HZ/TICK_HZ-1 and wraps; tick=1 while it equals the terminal value.
  - Free-running: not affected by pause, load or timer.
- Step:
  - step = !pause && (timer ? tick : 1).
  - Changing timer takes effect on the next edge, with no glitch or extra step.
- Priority per edge: load > step > hold.
- Load (load=1):
  - Accepted only if every digit is 0..9 and the value is at most MAX_COUNT.
  - On accept: count takes load_value on the next edge, and no step occurs that cycle.
  - On reject: count holds and load_err=1 for exactly one cycle.
  - Load is honoured while paused.
- Up-step:
  - Digit 0 increments; a digit at 9 rolls to 0 and carries into the next digit in the same cycle (single-cycle full-chain carry).
  - At count==MAX_COUNT the next step sets count=0 and wrap=1 for that one cycle.
- Down-step (macro only):
  - A digit at 0 rolls to 9 and borrows from the next digit.
  - At count==0 the next step sets count=MAX_COUNT and wrap=1.
- Count latency: count changes 1 cycle after the step/load condition is sampled.
- Segments:
  - Combinational from the registered count; valid in the same cycle as count_bcd.
  - Patterns 0..9: 3F,06,5B,4F,66,6D,7D,07,7F,6F.
  - Any other nibble (not reachable) decodes to 00.
- wrap and load_err are registered. They are 0 in every cycle where their condition did not occur.
- Reset mid-count clears state immediately, regardless of CLK; counting resumes on the first edge after RST rises.

Optional Feature:
Macro: BCD_CHAIN_DOWN_EN.
- Defined: the down input selects direction on each step, with the borrow and wrap rules above. Switching direction takes effect on the next step and leaves the value unchanged.
- Undefined: down is ignored, the counter is up-only, and no down-count logic is synthesised. The port remains in the interface.

Test Plan:
1. Reset: RST=0 mid-run with DIGITS=2 -> count_bcd=8'h00, segments=14'h1FBF, wrap=0, all asynchronously.
2. Wrap: DIGITS=2, MAX_COUNT=59, timer=0, pause=0, run 60 cycles from 0 -> count follows 00..59 with carry at 09->10, returns to 00, wrap high exactly on the cycle count reads 00.
3. Timer and pause: CLK_HZ=10, TICK_HZ=1, timer=1 -> one step every 10 cycles; pause=1 for 25 cycles -> count frozen; release -> stepping resumes, aligned to the free-running divider.
4. Load: load_value=8'h42 -> count 42 next cycle; load_value=8'h7A -> load_err 1 cycle, count unchanged; load together with a step -> load wins.
5. Down (macro defined): from 8'h01, down=1 -> 00, then 59 with wrap=1; from 10 -> 09.
6. Width: DIGITS=4, MAX_COUNT=9999, preset 0999 then one step -> 1000 via the full carry chain in a single cycle.
